// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the core's memory-side blocks
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } inst_t;
  localparam logic [7:0] WMASK_B = 8'h01;
  localparam logic [7:0] WMASK_H = 8'h03;
  localparam logic [7:0] WMASK_W = 8'h0f;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; a tie goes to whoever was not granted last
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output owner_t     gnt,
  output logic       gnt_valid
);
  owner_t last;
  always_comb begin
    gnt_valid = |req;
    gnt = req == 2'b11 ? (last == OWN_IFU ? OWN_LSU : OWN_IFU) : (req[1] ? OWN_LSU : OWN_IFU);
  end
  always_ff @(posedge clk)
    if (reset) last <= OWN_IFU;
    else if (take) last <= gnt;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, one transaction at a time
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_resp_valid,
  output logic [AW-1:0] ifu_rdata,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic [AW-1:0] lsu_wdata,
  input  logic          lsu_wen,
  input  logic [7:0]    lsu_wmask,
  output logic          lsu_resp_valid,
  output logic [AW-1:0] lsu_rdata,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  output logic          mem_wen,
  output logic [7:0]    mem_wmask,
  input  logic          mem_resp_valid,
  input  logic [AW-1:0] mem_rdata,
  output logic          err
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t state, state_n;
  owner_t owner_q, gnt;
  logic gnt_valid, hs, timeout, idle, resp;
  logic [AW-1:0] addr_q, wdata_q, rdata_q;
  logic wen_q;
  logic [7:0] wmask_q;
  logic [CW-1:0] cnt;
  rr_arb2 u_arb (
    .clk(clk), .reset(reset), .req({lsu_req_valid, ifu_req_valid}),
    .take(hs), .gnt(gnt), .gnt_valid(gnt_valid)
  );
  // handshake outputs are masked by reset so nothing escapes in the reset cycle
  always_comb begin
    idle = state == IDLE && !reset;
    resp = state == RESP && !reset;
    ifu_req_ready = idle && gnt_valid && gnt == OWN_IFU;
    lsu_req_ready = idle && gnt_valid && gnt == OWN_LSU;
    hs = (ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready);
    timeout = state == WAIT && !mem_resp_valid && cnt == CW'(TIMEOUT - 1);
    mem_req_valid = state == REQ && !reset;
    mem_addr = addr_q;
    mem_wdata = wdata_q;
    mem_wen = wen_q;
    mem_wmask = wmask_q;
    ifu_resp_valid = resp && owner_q == OWN_IFU;
    lsu_resp_valid = resp && owner_q == OWN_LSU;
    ifu_rdata = rdata_q;
    lsu_rdata = rdata_q;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = hs ? REQ : IDLE;
      REQ:  state_n = mem_req_ready ? WAIT : REQ;
      WAIT: state_n = (mem_resp_valid || timeout) ? RESP : WAIT;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      owner_q <= OWN_IFU;
      addr_q <= '0;
      wdata_q <= '0;
      wen_q <= 1'b0;
      wmask_q <= '0;
      rdata_q <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (hs) begin
        owner_q <= gnt;
        addr_q <= gnt == OWN_LSU ? lsu_addr : ifu_addr;
        wdata_q <= gnt == OWN_LSU ? lsu_wdata : '0;
        wen_q <= gnt == OWN_LSU && lsu_wen;
        wmask_q <= gnt == OWN_LSU ? lsu_wmask : '0;
      end
      cnt <= state == WAIT ? cnt + CW'(1) : '0;
      if (state == WAIT && mem_resp_valid) rdata_q <= mem_rdata;
      else if (timeout) rdata_q <= '0;
      if (timeout || (mem_resp_valid && state != WAIT)) err <= 1'b1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks plus a response scoreboard for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int TO = 8;
  typedef struct packed {logic own; logic [AW-1:0] data;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [AW-1:0] ifu_addr, ifu_rdata;
  logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [AW-1:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0] lsu_wmask, mem_wmask;
  logic mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, err;
  logic [AW-1:0] mem_addr, mem_wdata, mem_rdata;
  int errors = 0, checks = 0;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  mem_arbiter #(.TIMEOUT(TO), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wen(lsu_wen), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .err(err)
  );
  // every response pulse must match the oldest expected response
  always @(negedge clk)
    if (!reset && (ifu_resp_valid === 1'b1 || lsu_resp_valid === 1'b1)) begin
      checks++;
      if (ifu_resp_valid && lsu_resp_valid) begin
        errors++;
        $display("FAIL sb_both: ifu_resp_valid=1 lsu_resp_valid=1, required one-hot");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: ifu=%b lsu=%b pulse, required none", ifu_resp_valid, lsu_resp_valid);
      end else begin
        e = sb.pop_front();
        if ({lsu_resp_valid, ifu_resp_valid ? ifu_rdata : lsu_rdata} !== {e.own, e.data}) begin
          errors++;
          $display("FAIL sb_resp: got own=%b data=%h, required own=%b data=%h",
                   lsu_resp_valid, ifu_resp_valid ? ifu_rdata : lsu_rdata, e.own, e.data);
        end
      end
    end
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic clear_inputs;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wen = 0; lsu_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
  endtask
  task automatic do_reset;
    clear_inputs();
    reset = 1; step(); reset = 0;
  endtask
  // called right after a request handshake edge; leaves the DUT in RESP
  task automatic serve(input logic [AW-1:0] data, input int ready_lat, input int resp_lat);
    mem_req_ready = 0; step(ready_lat);
    mem_req_ready = 1; step();
    mem_req_ready = 0; step(resp_lat);
    mem_resp_valid = 1; mem_rdata = data; step();
    mem_resp_valid = 0; mem_rdata = '0;
  endtask
  task automatic test_reset;
    clear_inputs();
    ifu_req_valid = 1; lsu_req_valid = 1; reset = 1;
    step(); #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, err});
    end
    clear_inputs(); reset = 0; step();
  endtask
  task automatic test_ifu_only;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1; #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      errors++; $display("FAIL ifu_grant: ready ifu/lsu=%b, required 10", {ifu_req_ready, lsu_req_ready});
    end
    sb.push_back('{own: 1'b0, data: 32'h0010_0073});
    step(); ifu_req_valid = 0; #1;
    checks++;
    if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, ifu_req_ready} !== {1'b1, 32'h8000_0000, 1'b0, 8'h0, 1'b0}) begin
      errors++;
      $display("FAIL ifu_memreq: valid=%b addr=%h wen=%b wmask=%h, required 1 80000000 0 00",
               mem_req_valid, mem_addr, mem_wen, mem_wmask);
    end
    step(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0010_0073; #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL ifu_wait_noreq: mem_req_valid=%b, required 0", mem_req_valid);
    end
    step(); mem_resp_valid = 0; #1;
    checks++;
    if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {2'b10, 32'h0010_0073}) begin
      errors++;
      $display("FAIL ifu_resp: ifu=%b lsu=%b data=%h, required 1 0 00100073", ifu_resp_valid, lsu_resp_valid, ifu_rdata);
    end
    step(); #1;
    checks++;
    if ({ifu_resp_valid, lsu_resp_valid, err} !== 3'b000) begin
      errors++; $display("FAIL ifu_after: ifu/lsu/err=%b, required 000", {ifu_resp_valid, lsu_resp_valid, err});
    end
  endtask
  task automatic test_back_to_back;
    do_reset();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000;
    for (int k = 0; k < 3; k++) begin
      logic own = (k % 2 == 0);
      logic [AW-1:0] a = own ? 32'h8000_1000 : 32'h8000_0004;
      logic [AW-1:0] d = 32'h1111_0000 + k;
      #1;
      checks++;
      if ({lsu_req_ready, ifu_req_ready} !== {own, !own}) begin
        errors++;
        $display("FAIL rr_grant%0d: lsu/ifu ready=%b, required %b", k, {lsu_req_ready, ifu_req_ready}, {own, !own});
      end
      sb.push_back('{own: own, data: d});
      step(); #1;
      checks++;
      if ({mem_req_valid, mem_addr} !== {1'b1, a}) begin
        errors++; $display("FAIL rr_addr%0d: valid=%b addr=%h, required 1 %h", k, mem_req_valid, mem_addr, a);
      end
      serve(d, 0, 0); #1;
      checks++;
      if ({lsu_resp_valid, ifu_resp_valid, ifu_req_ready, lsu_req_ready} !== {own, !own, 2'b00}) begin
        errors++;
        $display("FAIL rr_resp%0d: lsu/ifu resp, ready=%b, required %b", k,
                 {lsu_resp_valid, ifu_resp_valid, ifu_req_ready, lsu_req_ready}, {own, !own, 2'b00});
      end
      if (k == 2) begin ifu_req_valid = 0; lsu_req_valid = 0; end
      step();
    end
  endtask
  task automatic test_store_stall;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1008; lsu_wdata = 32'hDEAD_BEEF; lsu_wen = 1; lsu_wmask = 8'hf; #1;
    checks++;
    if (lsu_req_ready !== 1'b1) begin
      errors++; $display("FAIL st_grant: lsu_req_ready=%b, required 1", lsu_req_ready);
    end
    sb.push_back('{own: 1'b1, data: 32'hCAFE_F00D});
    step();
    lsu_req_valid = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wen = 0; lsu_wmask = '0;
    for (int i = 0; i < 6; i++) begin
      mem_req_ready = (i == 5); #1;
      checks++;
      if ({mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wmask} !== {1'b1, 32'h8000_1008, 32'hDEAD_BEEF, 1'b1, 8'hf}) begin
        errors++;
        $display("FAIL st_hold%0d: valid=%b addr=%h wdata=%h wen=%b wmask=%h, required 1 80001008 deadbeef 1 0f",
                 i, mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_wmask);
      end
      step();
    end
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D; step();
    mem_resp_valid = 0; #1;
    checks++;
    if ({lsu_resp_valid, lsu_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL st_resp: valid=%b data=%h, required 1 cafef00d", lsu_resp_valid, lsu_rdata);
    end
    step(); #1;
    checks++;
    if (lsu_resp_valid !== 1'b0) begin
      errors++; $display("FAIL st_pulse: lsu_resp_valid=%b one cycle later, required 0", lsu_resp_valid);
    end
  endtask
  task automatic test_timeout;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100; #1;
    sb.push_back('{own: 1'b0, data: '0});
    step(); ifu_req_valid = 0; mem_req_ready = 1; step(); mem_req_ready = 0;
    for (int i = 0; i < TO; i++) begin
      #1;
      checks++;
      if ({err, ifu_resp_valid, mem_req_valid} !== 3'b000) begin
        errors++;
        $display("FAIL to_wait%0d: err/resp/memreq=%b, required 000", i, {err, ifu_resp_valid, mem_req_valid});
      end
      step();
    end
    #1;
    checks++;
    if ({err, ifu_resp_valid, ifu_rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL to_resp: err=%b valid=%b data=%h, required 1 1 0", err, ifu_resp_valid, ifu_rdata);
    end
    step(); lsu_req_valid = 1; #1;
    checks++;
    if ({ifu_resp_valid, err, lsu_req_ready} !== 3'b011) begin
      errors++; $display("FAIL to_idle: resp/err/lsu_ready=%b, required 011", {ifu_resp_valid, err, lsu_req_ready});
    end
    lsu_req_valid = 0;
  endtask
  task automatic test_reset_in_wait;
    do_reset(); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL rw_clear: err=%b after reset, required 0", err);
    end
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
    step(); ifu_req_valid = 0; mem_req_ready = 1; step(); mem_req_ready = 0; step();
    reset = 1; step(); reset = 0;
    mem_resp_valid = 1; mem_rdata = 32'h0000_0123; step(); mem_resp_valid = 0; #1;
    checks++;
    if ({err, ifu_resp_valid, lsu_resp_valid} !== 3'b100) begin
      errors++; $display("FAIL rw_late: err/ifu/lsu=%b, required 100", {err, ifu_resp_valid, lsu_resp_valid});
    end
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; #1;
    checks++;
    if (lsu_req_ready !== 1'b1) begin
      errors++; $display("FAIL rw_next_grant: lsu_req_ready=%b, required 1", lsu_req_ready);
    end
    sb.push_back('{own: 1'b1, data: 32'h5A5A_0001});
    step(); lsu_req_valid = 0; serve(32'h5A5A_0001, 2, 1); #1;
    checks++;
    if ({lsu_resp_valid, lsu_rdata} !== {1'b1, 32'h5A5A_0001}) begin
      errors++; $display("FAIL rw_next_resp: valid=%b data=%h, required 1 5a5a0001", lsu_resp_valid, lsu_rdata);
    end
    step();
  endtask
  task automatic test_spurious;
    do_reset();
    mem_resp_valid = 1; mem_rdata = 32'h0000_0BAD; #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL sp_before: err=%b, required 0", err);
    end
    step(); mem_resp_valid = 0; #1;
    checks++;
    if ({err, ifu_resp_valid, lsu_resp_valid} !== 3'b100) begin
      errors++; $display("FAIL sp_err: err/ifu/lsu=%b, required 100", {err, ifu_resp_valid, lsu_resp_valid});
    end
    step(3); #1;
    checks++;
    if ({err, ifu_resp_valid, lsu_resp_valid} !== 3'b100) begin
      errors++; $display("FAIL sp_sticky: err/ifu/lsu=%b, required 100", {err, ifu_resp_valid, lsu_resp_valid});
    end
  endtask
  initial begin
    test_reset();
    test_ifu_only();
    test_back_to_back();
    test_store_stall();
    test_timeout();
    test_reset_in_wait();
    test_spurious();
    step(2);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 256: maximum cycles spent in WAIT before the error flag is raised.
REQ-002 The block SHALL have parameter AW, default 32: address and data width.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 ifu_req_valid / ifu_req_ready  in / out  1 / 1  instruction-fetch request handshake.
REQ-006 ifu_addr  in  AW  fetch address; read-only requester.
REQ-007 ifu_resp_valid / ifu_rdata  out / out  1 / AW  fetch response pulse and data.
REQ-008 lsu_req_valid / lsu_req_ready  in / out  1 / 1  load/store request handshake.
REQ-009 lsu_addr, lsu_wdata  in  AW each; lsu_wen  in  1; lsu_wmask  in  8  (store byte mask: 8'h1 sb, 8'h3 sh, 8'hf sw).
REQ-010 lsu_resp_valid / lsu_rdata  out / out  1 / AW  load data or store acknowledge.
REQ-011 mem_req_valid / mem_req_ready  out / in  1 / 1  shared memory-port request handshake.
REQ-012 mem_addr, mem_wdata  out  AW each; mem_wen  out  1; mem_wmask  out  8.
REQ-013 mem_resp_valid / mem_rdata  in / in  1 / AW  memory response.
REQ-014 err  out  1  sticky error flag (timeout or spurious response).

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, RESP.
REQ-016 In IDLE, ready SHALL be asserted combinationally to exactly one requester, the grant winner; ready SHALL be 0 in all other states.
REQ-017 Grant with one requester valid: that requester.
REQ-018 Grant with both valid: round-robin, the requester not granted last; the last-grant pointer resets to IFU, so the LSU wins the first tie.
REQ-019 On handshake (valid & ready), the block SHALL latch the owner, address, wen, wdata and wmask, and go IDLE->REQ.
REQ-020 For an IFU grant, the latched wen and wmask SHALL be 0.
REQ-021 In REQ, mem_req_valid=1 with the latched fields, held stable until mem_req_ready; on mem_req_ready, REQ->WAIT.
REQ-022 In WAIT, on mem_resp_valid, capture mem_rdata and go WAIT->RESP.
REQ-023 In RESP, pulse owner_resp_valid=1 with the captured data for exactly 1 cycle, then RESP->IDLE; the non-owner's resp_valid SHALL stay 0.
REQ-024 Minimum round trip with zero-wait memory SHALL be 4 cycles: handshake cycle N, mem_req_valid N+1, mem_resp_valid N+2, resp_valid N+3.
REQ-025 A new request SHALL be accepted no earlier than the IDLE cycle following RESP (one outstanding transaction).
REQ-026 Store transactions SHALL complete through the same RESP pulse, with lsu_rdata = captured mem_rdata, whose value is don't-care.
REQ-027 mem_resp_valid outside WAIT SHALL be ignored for data and SHALL set err.
REQ-028 mem_req_valid SHALL never be asserted outside REQ.
REQ-029 A cycle counter SHALL clear on WAIT entry; if it reaches TIMEOUT while still in WAIT, err is set, owner_resp_valid pulses with rdata=0, and the FSM goes WAIT->RESP->IDLE.
REQ-030 err SHALL remain set until reset.
REQ-031 Requester valid deasserted while not ready SHALL have no effect; no request is latched.

Reset
REQ-032 On reset, state=IDLE, last-grant=IFU, err=0, counter=0, latched fields=0.
REQ-033 On reset, every valid/ready output SHALL be 0 in the reset cycle.
REQ-034 Reset mid-transaction SHALL drop the transaction without any response pulse; a later mem_resp_valid for it SHALL set err.

Structure
REQ-035 The state enum SHALL be defined in the shared package alongside inst_t and alu_op_t.
REQ-036 The owner encoding (OWN_IFU, OWN_LSU) and the wmask constants SHALL be defined in that same package.
REQ-037 The block SHALL have one sub-module, rr_arb2: a 2-way round-robin grant with a registered last-grant pointer.

Verification
REQ-038 IFU-only: ifu addr 0x80000000, memory ready immediately and returns 0x00100073 one cycle later -> ifu_resp_valid at handshake+3 with 0x00100073; lsu_resp_valid stays 0.
REQ-039 Simultaneous IFU 0x80000004 and LSU load 0x80001000 after reset -> LSU served first, IFU granted in the next IDLE cycle; then simultaneous again -> IFU then LSU.
REQ-040 LSU sw addr 0x80001008, wdata 0xDEADBEEF, wmask 8'hf, mem_req_ready held low for 5 cycles -> mem fields stable all 5 cycles; lsu_resp_valid is one pulse.
REQ-041 Memory never responds, TIMEOUT=8 -> err=1 after 8 WAIT cycles; one resp pulse with rdata 0; return to IDLE.
REQ-042 Reset asserted in WAIT, then mem_resp_valid -> no resp pulse; err=1; next request served normally.
REQ-043 Spurious mem_resp_valid in IDLE -> err=1; no resp pulse on either requester.
